// File: rtl/pr_alloc_scheduler_pkg.sv
// Shared constants and types for the physical-register allocation scheduler.
// PR0..PR_ARCH_BASE-1 hold architectural state and never enter the free pool.
package pr_alloc_scheduler_pkg;

  localparam int PR_ARCH_BASE         = 32;
  localparam int NUM_PHY_REGS_DEFAULT = 64;

  function automatic int prWidth(input int numPhyRegs);
    return $clog2(numPhyRegs);
  endfunction

  localparam int PRW_DEFAULT = prWidth(NUM_PHY_REGS_DEFAULT);

  typedef logic [PRW_DEFAULT-1:0] pr_idx_t;

endpackage

// File: rtl/pr_find_first.sv
// Lowest-set-bit finder: returns the index of the lowest set bit of the mask
// and whether any bit was set at all.
module pr_find_first #(
  parameter int N = 64,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_mask,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx   = W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pr_alloc_scheduler.sv
// Free-pool owner for renamable physical registers: round-robin same-cycle grants,
// quarantine of released PRs until the register file reports them idle.
module pr_alloc_scheduler
  import pr_alloc_scheduler_pkg::*;
#(
  parameter int  NUM_PHY_REGS = NUM_PHY_REGS_DEFAULT,
  parameter int  NUM_SICS     = 2,
  localparam int PRW          = prWidth(NUM_PHY_REGS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_SICS-1:0]     i_alloc_req,
  output logic [NUM_SICS-1:0]     o_alloc_gnt,
  output logic [PRW-1:0]          o_alloc_gnt_pr [NUM_SICS],
  output logic [NUM_SICS-1:0]     o_rf_alloc_wen,
  output logic [PRW-1:0]          o_rf_alloc_pr  [NUM_SICS],
  input  logic [NUM_SICS-1:0]     i_rel_valid,
  input  logic [PRW-1:0]          i_rel_pr       [NUM_SICS],
  input  logic [NUM_PHY_REGS-1:0] i_pr_not_idle,
  output logic [PRW:0]            o_free_count,
  output logic                    o_pool_empty,
  output logic                    o_err_bad_release
);

  localparam int                    RRW         = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;
  localparam logic [NUM_PHY_REGS-1:0] RESET_FREE  = {NUM_PHY_REGS{1'b1}} << PR_ARCH_BASE;
  localparam logic [PRW:0]          RESET_COUNT = (PRW+1)'(NUM_PHY_REGS - PR_ARCH_BASE);

  logic [NUM_PHY_REGS-1:0] r_freeMap, r_quarMap;
  logic [RRW-1:0]          r_rrPtr;
  logic [PRW:0]            r_freeCount;
  logic                    r_poolEmpty, r_errBadRelease;

  logic [NUM_SICS-1:0]     w_slotTake;
  logic [PRW-1:0]          w_slotPr  [NUM_SICS];
  logic [RRW-1:0]          w_slotSic [NUM_SICS];
  logic [NUM_PHY_REGS-1:0] w_availLast, w_grantMask, w_reclaimMask, w_quarSet;
  logic                    w_relErr;
  logic [PRW:0]            w_nextCount;

  // Slot k serves requester rr_ptr+k and sees the pool minus picks of earlier slots.
  for (genvar k = 0; k < NUM_SICS; k++) begin : gSlot
    logic [NUM_PHY_REGS-1:0] w_availIn, w_availOut;
    logic [PRW-1:0]          w_idx;
    logic                    w_found, w_take;
    logic [RRW-1:0]          w_sic;
    int                      w_sum;

    if (k == 0) begin : gFirst
      assign w_availIn = r_freeMap;
    end else begin : gNext
      assign w_availIn = gSlot[k-1].w_availOut;
    end

    pr_find_first #(.N(NUM_PHY_REGS), .W(PRW)) uFind (
      .i_mask (w_availIn),
      .o_idx  (w_idx),
      .o_found(w_found)
    );

    assign w_sum      = int'(r_rrPtr) + k;
    assign w_sic      = RRW'((w_sum >= NUM_SICS) ? (w_sum - NUM_SICS) : w_sum);
    assign w_take     = i_alloc_req[w_sic] & w_found & ~i_rst;
    assign w_availOut = w_take ? (w_availIn & ~(NUM_PHY_REGS'(1) << w_idx)) : w_availIn;

    assign w_slotTake[k] = w_take;
    assign w_slotPr[k]   = w_idx;
    assign w_slotSic[k]  = w_sic;
  end

  assign w_availLast = gSlot[NUM_SICS-1].w_availOut;
  assign w_grantMask = r_freeMap & ~w_availLast;

  always_comb begin
    o_alloc_gnt = '0;
    for (int s = 0; s < NUM_SICS; s++) o_alloc_gnt_pr[s] = '0;
    for (int k = 0; k < NUM_SICS; k++) begin
      if (w_slotTake[k]) begin
        o_alloc_gnt[w_slotSic[k]]    = 1'b1;
        o_alloc_gnt_pr[w_slotSic[k]] = w_slotPr[k];
      end
    end
  end

  assign o_rf_alloc_wen = o_alloc_gnt;
  assign o_rf_alloc_pr  = o_alloc_gnt_pr;

  // Lower-numbered SIC wins a duplicate release; the loser only raises the error.
  always_comb begin
    w_quarSet = '0;
    w_relErr  = 1'b0;
    for (int s = 0; s < NUM_SICS; s++) begin
      if (i_rel_valid[s]) begin
        if (int'(i_rel_pr[s]) >= PR_ARCH_BASE && !r_freeMap[i_rel_pr[s]] &&
            !r_quarMap[i_rel_pr[s]] && !w_quarSet[i_rel_pr[s]])
          w_quarSet[i_rel_pr[s]] = 1'b1;
        else
          w_relErr = 1'b1;
      end
    end
  end

  assign w_reclaimMask = r_quarMap & ~i_pr_not_idle;
  assign w_nextCount   = r_freeCount - (PRW+1)'($countones(w_grantMask))
                                     + (PRW+1)'($countones(w_reclaimMask));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_freeMap       <= RESET_FREE;
      r_quarMap       <= '0;
      r_rrPtr         <= '0;
      r_freeCount     <= RESET_COUNT;
      r_poolEmpty     <= 1'b0;
      r_errBadRelease <= 1'b0;
    end else begin
      r_freeMap   <= (r_freeMap & ~w_grantMask) | w_reclaimMask;
      r_quarMap   <= (r_quarMap & ~w_reclaimMask) | w_quarSet;
      r_freeCount <= w_nextCount;
      r_poolEmpty <= (w_nextCount == '0);
      if (w_relErr) r_errBadRelease <= 1'b1;
      if (|w_slotTake)
        r_rrPtr <= (r_rrPtr == RRW'(NUM_SICS - 1)) ? '0 : r_rrPtr + 1'b1;
    end
  end

  assert property (@(posedge i_clk) disable iff (i_rst)
    r_freeCount == (PRW+1)'($countones(r_freeMap)));

  assign o_free_count      = r_freeCount;
  assign o_pool_empty      = r_poolEmpty;
  assign o_err_bad_release = r_errBadRelease;

endmodule

// File: tb/tb_pr_alloc_scheduler.sv
// Self-checking bench for pr_alloc_scheduler (64 PRs, 2 SICs): table vectors,
// a cycle model feeding a grant scoreboard, and hand-written release/reset sequences.
module tb_pr_alloc_scheduler;
  import pr_alloc_scheduler_pkg::*;

  logic        clk, rst;
  logic [1:0]  req, gnt, wen, relValid;
  pr_idx_t     gntPr [2];
  pr_idx_t     rfPr  [2];
  pr_idx_t     relPr [2];
  logic [63:0] notIdle;
  logic [6:0]  freeCount;
  logic        poolEmpty, err;

  pr_alloc_scheduler #(.NUM_PHY_REGS(64), .NUM_SICS(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_alloc_req(req), .o_alloc_gnt(gnt),
    .o_alloc_gnt_pr(gntPr), .o_rf_alloc_wen(wen), .o_rf_alloc_pr(rfPr),
    .i_rel_valid(relValid), .i_rel_pr(relPr), .i_pr_not_idle(notIdle),
    .o_free_count(freeCount), .o_pool_empty(poolEmpty), .o_err_bad_release(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [1:0] gnt; logic [5:0] pr0; logic [5:0] pr1; } exp_t;
  typedef struct { logic [1:0] req; logic [1:0] expGnt; logic [5:0] expPr0; logic [5:0] expPr1; int expCount; } vec_t;

  exp_t        sbQ[$];
  vec_t        vecs[7];
  int          total = 0, bad = 0;
  logic [63:0] mFree, mQuar;
  int          mRr, mCount;
  logic        mErr, mEmpty;
  logic [1:0]  lastGnt;
  logic [5:0]  lastPr0, lastPr1;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelGrants(input logic [1:0] r, input logic rs, output logic [1:0] g,
                                      output logic [5:0] p0, output logic [5:0] p1, output logic [63:0] gm);
    logic [63:0] avail;
    g = '0; p0 = '0; p1 = '0; gm = '0; avail = mFree;
    if (!rs) begin
      for (int k = 0; k < 2; k++) begin
        int s;
        s = (mRr + k) % 2;
        if (r[s]) begin
          for (int i = 0; i < 64; i++) begin
            if (avail[i]) begin
              g[s] = 1'b1;
              if (s == 0) p0 = 6'(i); else p1 = 6'(i);
              avail[i] = 1'b0;
              gm[i] = 1'b1;
              break;
            end
          end
        end
      end
    end
  endfunction

  function automatic void modelUpdate(input logic rs, input logic [1:0] rv, input logic [5:0] rp0,
                                      input logic [5:0] rp1, input logic [63:0] ni, input logic [63:0] gm);
    logic [63:0] relSet, rec;
    logic        relErr;
    if (rs) begin
      mFree = {32'hFFFF_FFFF, 32'h0}; mQuar = '0; mRr = 0; mCount = 32; mErr = 1'b0; mEmpty = 1'b0;
    end else begin
      relSet = '0; relErr = 1'b0;
      for (int s = 0; s < 2; s++) begin
        logic [5:0] p;
        p = (s == 0) ? rp0 : rp1;
        if (rv[s]) begin
          if (p >= 6'd32 && !mFree[p] && !mQuar[p] && !relSet[p]) relSet[p] = 1'b1;
          else relErr = 1'b1;
        end
      end
      rec    = mQuar & ~ni;
      mFree  = (mFree & ~gm) | rec;
      mQuar  = (mQuar & ~rec) | relSet;
      mCount = mCount - $countones(gm) + $countones(rec);
      mErr   = mErr | relErr;
      if (gm != '0) mRr = (mRr + 1) % 2;
      mEmpty = (mCount == 0);
    end
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() == 0) begin
      checkVal("scoreboard_empty", 64'(1), 64'(0));
    end else begin
      e = sbQ.pop_front();
      lastGnt = gnt; lastPr0 = gntPr[0]; lastPr1 = gntPr[1];
      checkVal("alloc_gnt", 64'(gnt), 64'(e.gnt));
      checkVal("alloc_gnt_pr0", 64'(gntPr[0]), 64'(e.pr0));
      checkVal("alloc_gnt_pr1", 64'(gntPr[1]), 64'(e.pr1));
      checkVal("rf_alloc_wen", 64'(wen), 64'(e.gnt));
      checkVal("rf_alloc_pr0", 64'(rfPr[0]), 64'(e.pr0));
      checkVal("rf_alloc_pr1", 64'(rfPr[1]), 64'(e.pr1));
    end
  endtask

  // One cycle: drive at negedge, check grants just before posedge, check state after it.
  task automatic applyStimulus(input logic rs, input logic [1:0] r, input logic [1:0] rv,
                               input logic [5:0] rp0, input logic [5:0] rp1, input logic [63:0] ni);
    exp_t        e;
    logic [63:0] gm;
    @(negedge clk);
    rst = rs; req = r; relValid = rv; relPr[0] = rp0; relPr[1] = rp1; notIdle = ni;
    modelGrants(r, rs, e.gnt, e.pr0, e.pr1, gm);
    sbQ.push_back(e);
    #4;
    checkOutput();
    @(posedge clk);
    modelUpdate(rs, rv, rp0, rp1, ni, gm);
    #1;
    checkVal("free_count", 64'(freeCount), 64'(mCount));
    checkVal("pool_empty", 64'(poolEmpty), 64'(mEmpty));
    checkVal("err_bad_release", 64'(err), 64'(mErr));
  endtask

  task automatic idle(input int n, input logic [63:0] ni);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 2'b00, 6'd0, 6'd0, ni);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] ni;
    bit          emptied;
    vecs[0] = '{2'b11, 2'b11, 6'd32, 6'd33, 30};
    vecs[1] = '{2'b11, 2'b11, 6'd35, 6'd34, 28};
    vecs[2] = '{2'b01, 2'b01, 6'd36, 6'd0,  27};
    vecs[3] = '{2'b01, 2'b01, 6'd37, 6'd0,  26};
    vecs[4] = '{2'b00, 2'b00, 6'd0,  6'd0,  26};
    vecs[5] = '{2'b10, 2'b10, 6'd0,  6'd38, 25};
    vecs[6] = '{2'b11, 2'b11, 6'd40, 6'd39, 23};

    rst = 1'b1; req = '0; relValid = '0; relPr[0] = '0; relPr[1] = '0; notIdle = '0;
    mFree = '0; mQuar = '0; mRr = 0; mCount = 0; mErr = 1'b0; mEmpty = 1'b0;

    applyStimulus(1'b1, 2'b00, 2'b00, 6'd0, 6'd0, '0);
    applyStimulus(1'b1, 2'b11, 2'b00, 6'd0, 6'd0, '0);
    checkVal("reset_gnt_held_low", 64'(lastGnt), 64'(0));
    checkVal("reset_free_count", 64'(freeCount), 64'(32));
    checkVal("reset_pool_empty", 64'(poolEmpty), 64'(0));
    checkVal("reset_err", 64'(err), 64'(0));

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, vecs[i].req, 2'b00, 6'd0, 6'd0, '0);
      checkVal($sformatf("vec%0d_gnt", i), 64'(lastGnt), 64'(vecs[i].expGnt));
      checkVal($sformatf("vec%0d_pr0", i), 64'(lastPr0), 64'(vecs[i].expPr0));
      checkVal($sformatf("vec%0d_pr1", i), 64'(lastPr1), 64'(vecs[i].expPr1));
      checkVal($sformatf("vec%0d_count", i), 64'(freeCount), 64'(vecs[i].expCount));
    end

    // PR40 stays quarantined while referenced, returns one edge after going idle.
    ni = 64'(1) << 40;
    applyStimulus(1'b0, 2'b00, 2'b01, 6'd40, 6'd0, ni);
    idle(5, ni);
    checkVal("pr40_held_count", 64'(freeCount), 64'(23));
    idle(1, '0);
    checkVal("pr40_reclaim_count", 64'(freeCount), 64'(24));
    applyStimulus(1'b0, 2'b01, 2'b00, 6'd0, 6'd0, '0);
    checkVal("pr40_regrant", 64'(lastPr0), 64'(40));

    // Drain the pool completely.
    emptied = 1'b0;
    for (int i = 0; i < 40 && !emptied; i++) begin
      applyStimulus(1'b0, 2'b11, 2'b00, 6'd0, 6'd0, '0);
      emptied = poolEmpty;
    end
    checkVal("drain_reached_empty", 64'(emptied), 64'(1));
    checkVal("drain_count", 64'(freeCount), 64'(0));
    applyStimulus(1'b0, 2'b11, 2'b00, 6'd0, 6'd0, '0);
    checkVal("empty_no_gnt", 64'(lastGnt), 64'(0));

    // Duplicate release of PR45 in one cycle: quarantined once, error flagged.
    applyStimulus(1'b0, 2'b00, 2'b11, 6'd45, 6'd45, '0);
    checkVal("dup_release_err", 64'(err), 64'(1));
    idle(1, '0);
    checkVal("dup_release_count", 64'(freeCount), 64'(1));

    // Reset with PR46 still quarantined discards it.
    ni = 64'(1) << 46;
    applyStimulus(1'b0, 2'b00, 2'b01, 6'd46, 6'd0, ni);
    idle(1, ni);
    applyStimulus(1'b1, 2'b11, 2'b00, 6'd0, 6'd0, ni);
    checkVal("midreset_gnt_low", 64'(lastGnt), 64'(0));
    checkVal("midreset_count", 64'(freeCount), 64'(32));
    checkVal("midreset_err", 64'(err), 64'(0));
    idle(3, '0);
    checkVal("midreset_quar_dropped", 64'(freeCount), 64'(32));

    // Releasing a free PR, then an architectural PR, both flag the error.
    applyStimulus(1'b0, 2'b00, 2'b01, 6'd33, 6'd0, '0);
    checkVal("free_release_err", 64'(err), 64'(1));
    checkVal("free_release_count", 64'(freeCount), 64'(32));
    applyStimulus(1'b1, 2'b00, 2'b00, 6'd0, 6'd0, '0);
    applyStimulus(1'b0, 2'b00, 2'b10, 6'd0, 6'd5, '0);
    idle(3, '0);
    checkVal("arch_release_sticky_err", 64'(err), 64'(1));
    checkVal("arch_release_count", 64'(freeCount), 64'(32));
    applyStimulus(1'b0, 2'b01, 2'b00, 6'd0, 6'd0, '0);
    checkVal("after_err_grant", 64'(lastPr0), 64'(32));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pr_alloc_scheduler.md
Name: pr_alloc_scheduler

Overview:
- Owns the pool of renamable physical registers (PR 32..NUM_PHY_REGS-1).
- Arbitrates allocation requests from NUM_SICS issue slots each cycle and drives the register file's per-SIC alloc port.
- Quarantines released PRs until the register file's pr_not_idle shows no SIC still references them, then returns them to the free pool.
- Sits between the Issue Controller and register_file.

Parameters:
- NUM_PHY_REGS, 64: total physical registers; power of two, at least 64.
- NUM_SICS, 2: requester/issue-slot count, 1..8.
- PR_ARCH_BASE, 32: first allocatable PR; PR0..31 are never allocated or freed.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- alloc_req[NUM_SICS]  in  1  SIC s wants a new PR this cycle.
- alloc_gnt[NUM_SICS]  out  1  request granted this cycle (combinational).
- alloc_gnt_pr[NUM_SICS]  out  PRW  granted PR index, valid when alloc_gnt[s]; PRW=$clog2(NUM_PHY_REGS).
- rf_alloc_wen[NUM_SICS]  out  1  to register_file alloc_wen; equals alloc_gnt.
- rf_alloc_pr[NUM_SICS]  out  PRW  to register_file alloc_pr; equals alloc_gnt_pr.
- rel_valid[NUM_SICS]  in  1  SIC s releases a PR (old mapping retired).
- rel_pr[NUM_SICS]  in  PRW  PR being released.
- pr_not_idle  in  NUM_PHY_REGS  from register_file; bit p=1 means some SIC references PR p.
- free_count  out  PRW+1  registered count of PRs in the free pool.
- pool_empty  out  1  free_count==0 (registered).
- err_bad_release  out  1  sticky error flag.

Behaviour:
- State:
  - free_map[NUM_PHY_REGS]
  - quar_map[NUM_PHY_REGS] (released, awaiting idle)
  - rr_ptr[$clog2(NUM_SICS)]
  - free_count
  - err flag
- Reset (rst=1 at posedge):
  - free_map bits PR_ARCH_BASE..N-1 = 1; bits 0..31 = 0.
  - quar_map = 0; rr_ptr = 0; err_bad_release = 0.
  - free_count = N-32 (32 for N=64); pool_empty = 0.
  - While rst is asserted, all alloc_gnt/rf_alloc_wen = 0.
- Allocation (same-cycle, combinational grant):
  - Visit requesters in order rr_ptr, rr_ptr+1, ... (mod NUM_SICS).
  - Each requesting SIC takes the lowest-index set bit of free_map not already taken by an earlier-visited SIC this cycle.
  - If no bit remains, alloc_gnt[s]=0; the requester retries next cycle.
  - alloc_gnt_pr for an ungranted slot = 0.
  - At posedge, granted bits are cleared in free_map.
  - register_file clears valid at the same edge, via rf_alloc_wen.
- Arbitration fairness: rr_ptr <= rr_ptr+1 (mod NUM_SICS) on any cycle with at least one grant; otherwise it holds.
- Release:
  - rel_valid with PR_ARCH_BASE <= rel_pr < N, free_map=0 and quar_map=0 sets quar_map[rel_pr] at posedge.
  - Any other release sets err_bad_release and is otherwise ignored. This covers pr<32, an already-free PR, an already-quarantined PR, and two SICs releasing the same PR in one cycle (the first wins, error is set).
- Reclaim:
  - Each posedge: free_map |= quar_map & ~pr_not_idle; the reclaimed bits clear in quar_map.
  - Uses registered quar_map only, so a release reaches the pool no earlier than 2 edges after rel_valid. It is allocatable in the cycle after that.
- Simultaneous events:
  - Grants, releases and reclaims in one cycle touch disjoint bits by construction.
  - A PR reclaimed at edge k is not grantable before cycle k+1.
- free_count:
  - next = free_count - grants + reclaims.
  - Never wraps; it is bounded by construction, and a simulation assertion checks that it equals popcount(free_map).
- Reset mid-operation: all quarantined and granted state is discarded; the pool returns to the full reset map. The Issue Controller resets in the same cycle.

Decomposition:
- Shared package:
  - PR_ARCH_BASE
  - PRW as a function of NUM_PHY_REGS
  - pr_idx_t typedef
- One sub-module, pr_find_first: given a mask, returns the lowest set index plus a found flag. Instantiate NUM_SICS copies, each on the free mask minus earlier picks.

Test Plan (N=64, S=2):
1. Reset, then alloc_req={1,1} on the first cycle -> gnt={1,1}, SIC0 gets PR32, SIC1 gets PR33; next cycle free_count=30, rr_ptr=1.
2. With rr_ptr=1, both requesting -> SIC1 gets the lower free PR (34) and SIC0 gets 35.
3. Allocate all 32 PRs -> pool_empty=1; any further alloc_req gives gnt=0 and no rf_alloc_wen.
4. Release PR40 with pr_not_idle[40]=1 for 5 cycles, then 0 -> PR40 stays out of the pool while referenced; free_count increments exactly 1 edge after the idle bit drops, and the next request is granted PR40.
5. Release PR5, then release PR33 while it is free -> err_bad_release=1, stays set; free_map and free_count unchanged.
6. Both SICs release PR45 in the same cycle -> PR45 is quarantined once and err_bad_release=1. Assert rst mid-test -> free_count=32, quar empty, err cleared.
